m_seq_gen_param: RTL and testbench
==================================

# m_seq_gen_param

Parametrised maximal-length (M) sequence chip generator for the spreading-code path. It contains a Fibonacci LFSR of configurable length and taps, and a clock-per-chip divider. It adds a run-time seed load, one-chip delay and advance phase slips, a chip strobe and a sequence-epoch strobe. It feeds the downstream code mixer and correlator blocks with one chip per `DIV` clocks.

## Interface
Parameters:
- `LFSR_W`, 11: LFSR length in bits, 3..32.
- `TAPS`, 11'h402: feedback mask. Feedback bit `fb = ^(q & TAPS)`. The default gives period 2047 (x^11+x^9+1).
- `SEED`, 11'h2AA: reset and epoch-reference state. Must be non-zero.
- `DIV`, 3052: clocks per chip, 2..65535.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: chip-rate counting enable.
- `load` in 1: synchronous reload of the LFSR from `seed_in` and restart of the divider.
- `seed_in` in LFSR_W: state loaded on `load`.
- `slip_dly` in 1: single-cycle pulse; delays the code by one chip.
- `slip_adv` in 1: single-cycle pulse; advances the code by one chip.
- `chip` out 1: current chip, equal to `q[LFSR_W-1]`, driven directly from a register bit.
- `chip_stb` out 1: one-clock pulse in the first clock a new chip is valid.
- `epoch` out 1: one-clock pulse in the first clock the LFSR state equals `SEED`.
- `state` out LFSR_W: current LFSR contents `q`.

## Operation
- Divider: `cnt` has width ceil(log2(DIV)). It counts 0..DIV-1 while `en`=1, wraps to 0 and holds while `en`=0. The terminal event `tc` is `en && cnt==DIV-1`.
- Single step: `q <= {q[LFSR_W-2:0], fb}`.
- On `tc` with no pending slip: single step.
- Pending flags `pd` and `pa` are set by `slip_dly` and `slip_adv`.
  - Each flag saturates at 1; extra pulses before the next `tc` are ignored.
  - Both flags are cleared on `tc`.
- On `tc` with `pd`=1, `pa`=0: no step. The current chip lasts 2*DIV clocks and `chip_stb` is not asserted.
- On `tc` with `pa`=1, `pd`=0: two steps are applied in one clock (feedback computed twice combinationally). `chip_stb` is asserted once.
- Both `pd` and `pa` set, or `slip_dly` and `slip_adv` asserted in the same cycle: they cancel, giving a normal single step.
- Slip pulses arriving in the same cycle as `tc` apply to the following `tc`.
- `load` has priority over everything:
  - `q <= seed_in`, `cnt <= 0`, `pd <= 0`, `pa <= 0`.
  - `chip_stb` is 0 in the next cycle.
  - `epoch` is 1 in the next cycle iff `seed_in == SEED`.
- `en`=0 freezes `cnt` and `q`. Slip pulses are still captured.

## Timing
- Reset values: `q`=SEED, `cnt`=0, `pd`=`pa`=0, `chip_stb`=0, `epoch`=0, `chip`=SEED[LFSR_W-1], `state`=SEED.
- Latency: `q` updates on the clock edge where `tc` is true. `chip`, `state`, `chip_stb` and `epoch` reflect it in the following cycle; there is no added pipeline.
- With `en` held high and no slips, `chip_stb` period is DIV clocks and `epoch` period is (2^LFSR_W-1)*DIV clocks for a primitive `TAPS`.
- `rst` asserted mid-chip aborts immediately. The first step after release occurs DIV clocks after the first `en`-high cycle.
- `epoch` is also asserted on a double step that lands on `SEED`. A double step that passes over `SEED` does not assert `epoch`.

## Configuration
- `M_SEQ_LOCKUP_GUARD_EN` defined:
  - A `load` with `seed_in==0` loads `SEED` instead.
  - Any all-zero `q` is forced to `SEED` on the next clock regardless of `en`, with `epoch` pulsed.
- Not defined: an all-zero state is accepted. `q` then stays at 0, `chip`=0, and `chip_stb` keeps pulsing each DIV with no `epoch`.

## Test plan
All scenarios use LFSR_W=11, TAPS=11'h402, SEED=11'h2AA, DIV=4.
- Reset release, `en`=1 → `chip_stb` every 4 clocks; first post-step `state`=11'h555 with `chip`=1, second `state`=11'h2AB; `epoch` exactly every 8188 clocks.
- `slip_dly` pulse mid-chip → next chip interval is 8 clocks and one `chip_stb` is missing. Subsequent chip sequence equals the unslipped sequence delayed by 4 clocks.
- `slip_adv` pulse at `state`=11'h2AA → the next `state` is 11'h2AB (11'h555 skipped), with one `chip_stb`.
- `slip_dly` and `slip_adv` in the same cycle, then a second `slip_adv` before `tc` → a single normal step.
- `load` with `seed_in`=11'h2AA at `cnt`=2 → `cnt`=0, `epoch`=1 in the next cycle, next step after 4 clocks; pending slips are discarded.
- `load` with `seed_in`=0:
  - With the guard macro: `state`=11'h2AA and `epoch`=1.
  - Without it: `state` stays 0 and `chip` stays 0 for 100 chips.

Source files
------------

// File: rtl/m_seq_gen_param.sv
// Maximal-length sequence chip generator: Fibonacci LFSR stepped once per DIV clocks,
// with seed load, one-chip delay/advance slips, chip and epoch strobes.
// Optional lockup guard: define M_SEQ_LOCKUP_GUARD_EN.
module m_seq_gen_param #(
  parameter int unsigned        LFSR_W = 11,
  parameter logic [LFSR_W-1:0]  TAPS   = 11'h402,
  parameter logic [LFSR_W-1:0]  SEED   = 11'h2AA,
  parameter int unsigned        DIV    = 3052
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              slip_dly,
  input  logic              slip_adv,
  output logic              chip,
  output logic              chip_stb,
  output logic              epoch,
  output logic [LFSR_W-1:0] state
);

  localparam int unsigned     CW      = $clog2(DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);
`ifdef M_SEQ_LOCKUP_GUARD_EN
  localparam logic [LFSR_W-1:0] ZERO  = {LFSR_W{1'b0}};
`endif

  logic [LFSR_W-1:0] q_q, q_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pd_q, pd_d, pa_q, pa_d;
  logic              stb_q, stb_d, ep_q, ep_d;
  logic              tc_s;
  logic [LFSR_W-1:0] step1_s, step2_s, load_val_s;

  // One Fibonacci shift: feedback is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] f_step(input logic [LFSR_W-1:0] s);
    f_step = {s[LFSR_W-2:0], ^(s & TAPS)};
  endfunction

  // Next-state: divider, slip flags, LFSR and strobes; load overrides all.
  always_comb begin
    tc_s    = en && (cnt_q == CNT_MAX);
    step1_s = f_step(q_q);
    step2_s = f_step(step1_s);
`ifdef M_SEQ_LOCKUP_GUARD_EN
    load_val_s = (seed_in == ZERO) ? SEED : seed_in;
`else
    load_val_s = seed_in;
`endif
    cnt_d = cnt_q;
    q_d   = q_q;
    pd_d  = pd_q;
    pa_d  = pa_q;
    stb_d = 1'b0;
    ep_d  = 1'b0;
    if (load) begin
      cnt_d = {CW{1'b0}};
      pd_d  = 1'b0;
      pa_d  = 1'b0;
      q_d   = load_val_s;
      ep_d  = (load_val_s == SEED);
    end else begin
      // Slips seen on the tc cycle belong to the following chip boundary.
      if (tc_s) begin
        cnt_d = {CW{1'b0}};
        pd_d  = slip_dly;
        pa_d  = slip_adv;
      end else if (en) begin
        cnt_d = cnt_q + CW'(1'b1);
        pd_d  = pd_q | slip_dly;
        pa_d  = pa_q | slip_adv;
      end else begin
        cnt_d = cnt_q;
        pd_d  = pd_q | slip_dly;
        pa_d  = pa_q | slip_adv;
      end
`ifdef M_SEQ_LOCKUP_GUARD_EN
      if (q_q == ZERO) begin
        q_d  = SEED;
        ep_d = 1'b1;
      end else
`endif
      if (tc_s) begin
        case ({pd_q, pa_q})
          2'b10: begin
            q_d   = q_q;
            stb_d = 1'b0;
          end
          2'b01: begin
            q_d   = step2_s;
            stb_d = 1'b1;
          end
          default: begin
            q_d   = step1_s;
            stb_d = 1'b1;
          end
        endcase
        ep_d = stb_d && (q_d == SEED);
      end else begin
        q_d = q_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= SEED;
      cnt_q <= {CW{1'b0}};
      pd_q  <= 1'b0;
      pa_q  <= 1'b0;
      stb_q <= 1'b0;
      ep_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      pd_q  <= pd_d;
      pa_q  <= pa_d;
      stb_q <= stb_d;
      ep_q  <= ep_d;
    end
  end

  assign chip     = q_q[LFSR_W-1];
  assign state    = q_q;
  assign chip_stb = stb_q;
  assign epoch    = ep_q;

endmodule

// File: tb/tb_m_seq_gen_param.sv
// Scoreboard bench for m_seq_gen_param (11-bit, taps 0x402, seed 0x2AA, DIV=4).
module tb_m_seq_gen_param;

  localparam logic [10:0] TB_TAPS = 11'h402;
  localparam logic [10:0] TB_SEED = 11'h2AA;

  logic        clk, rst, en, load, slip_dly, slip_adv;
  logic [10:0] seed_in;
  logic        chip, chip_stb, epoch;
  logic [10:0] state;

  typedef struct packed {
    logic [10:0] st;
    logic        stb;
    logic        ep;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks;
  int          n_fail;
  logic [10:0] m_q;
  int          m_cnt;
  logic        m_pd, m_pa;

  m_seq_gen_param #(.LFSR_W(11), .TAPS(TB_TAPS), .SEED(TB_SEED), .DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
    .slip_dly(slip_dly), .slip_adv(slip_adv),
    .chip(chip), .chip_stb(chip_stb), .epoch(epoch), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] m_step(input logic [10:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 11; i++) if (TB_TAPS[i]) fb = fb ^ s[i];
    return {s[9:0], fb};
  endfunction

  function automatic logic [10:0] m_step_n(input logic [10:0] s, input int n);
    logic [10:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = m_step(r);
    return r;
  endfunction

  task automatic model_reset();
    m_q = TB_SEED; m_cnt = 0; m_pd = 1'b0; m_pa = 1'b0;
  endtask

  // Drive one cycle of stimulus, push the expected outputs, then compare after the edge.
  task automatic cycle(input logic en_v, input logic load_v, input logic [10:0] seed_v,
                       input logic dly_v, input logic adv_v);
    exp_t e;
    logic tc, force_z;
    en = en_v; load = load_v; seed_in = seed_v; slip_dly = dly_v; slip_adv = adv_v;
    tc = en_v && (m_cnt == 3);
    force_z = 1'b0;
`ifdef M_SEQ_LOCKUP_GUARD_EN
    force_z = (m_q == 11'h000);
`endif
    e.stb = 1'b0; e.ep = 1'b0;
    if (load_v) begin
      m_q = seed_v;
`ifdef M_SEQ_LOCKUP_GUARD_EN
      if (seed_v == 11'h000) m_q = TB_SEED;
`endif
      m_cnt = 0; m_pd = 1'b0; m_pa = 1'b0;
      e.ep = (m_q == TB_SEED);
    end else begin
      if (force_z) begin
        m_q = TB_SEED; e.ep = 1'b1;
      end else if (tc) begin
        if (m_pd && !m_pa) begin
          e.stb = 1'b0;
        end else if (m_pa && !m_pd) begin
          m_q = m_step(m_step(m_q)); e.stb = 1'b1; e.ep = (m_q == TB_SEED);
        end else begin
          m_q = m_step(m_q); e.stb = 1'b1; e.ep = (m_q == TB_SEED);
        end
      end
      if (tc) begin
        m_cnt = 0; m_pd = dly_v; m_pa = adv_v;
      end else begin
        m_pd = m_pd | dly_v; m_pa = m_pa | adv_v;
        if (en_v) m_cnt = m_cnt + 1;
      end
    end
    e.st = m_q;
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check_eq("state", state, e.st);
    check_eq("chip", chip, e.st[10]);
    check_eq("chip_stb", chip_stb, e.stb);
    check_eq("epoch", epoch, e.ep);
  endtask

  // Run enabled idle cycles until a chip strobe, bounded; n = cycles taken.
  task automatic run_chip(output int n);
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 11'h000, 1'b0, 1'b0);
      n++;
    end while (!chip_stb && n < 20);
    if (!chip_stb) check_eq("stb_timeout", n, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, ep_n, ep1, ep2;
    logic [10:0] p_seed, pp_seed;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 11'h000; slip_dly = 1'b0; slip_adv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", state, TB_SEED);
    check_eq("rst_chip", chip, 1'b0);
    check_eq("rst_stb", chip_stb, 1'b0);
    check_eq("rst_epoch", epoch, 1'b0);
    rst = 1'b0;
    model_reset();

    // Free run over two full sequence periods.
    ep_n = 0; ep1 = 0; ep2 = 0;
    for (int i = 1; i <= 16376; i++) begin
      cycle(1'b1, 1'b0, 11'h000, 1'b0, 1'b0);
      if (epoch) begin
        ep_n++;
        if (ep_n == 1) ep1 = i;
        if (ep_n == 2) ep2 = i;
      end
      if (i == 4) begin
        check_eq("first_step", state, 11'h555);
        check_eq("first_chip", chip, 1'b1);
      end
      if (i == 8) check_eq("second_step", state, 11'h2AB);
    end
    check_eq("epoch_count", ep_n, 2);
    check_eq("epoch_first", ep1, 8188);
    check_eq("epoch_period", ep2 - ep1, 8188);

    // Delay slip mid-chip: one strobe missing, interval 8.
    cycle(1'b1, 1'b0, 11'h000, 1'b1, 1'b0);
    run_chip(n);
    check_eq("dly_interval", n + 1, 8);

    // Load at cnt=2 discards pending slips.
    cycle(1'b1, 1'b0, 11'h000, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 11'h000, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, TB_SEED, 1'b0, 1'b0);
    check_eq("load_state", state, TB_SEED);
    check_eq("load_epoch", epoch, 1'b1);
    check_eq("load_stb", chip_stb, 1'b0);
    run_chip(n);
    check_eq("load_interval", n, 4);
    check_eq("load_next", state, 11'h555);

    // Advance slip from the seed skips 0x555.
    cycle(1'b1, 1'b1, TB_SEED, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 11'h000, 1'b0, 1'b1);
    run_chip(n);
    check_eq("adv_interval", n + 1, 4);
    check_eq("adv_state", state, 11'h2AB);

    // Simultaneous slips cancel; a further advance saturates.
    cycle(1'b1, 1'b1, TB_SEED, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 11'h000, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 11'h000, 1'b0, 1'b1);
    run_chip(n);
    check_eq("cancel_interval", n + 2, 4);
    check_eq("cancel_state", state, 11'h555);

    // Double step landing on the seed pulses epoch; passing over it does not.
    p_seed  = m_step_n(TB_SEED, 2046);
    pp_seed = m_step_n(TB_SEED, 2045);
    cycle(1'b1, 1'b1, pp_seed, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 11'h000, 1'b0, 1'b1);
    run_chip(n);
    check_eq("adv_land_state", state, TB_SEED);
    check_eq("adv_land_epoch", epoch, 1'b1);
    cycle(1'b1, 1'b1, p_seed, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 11'h000, 1'b0, 1'b1);
    run_chip(n);
    check_eq("adv_over_state", state, 11'h555);
    check_eq("adv_over_epoch", epoch, 1'b0);

    // en low freezes state but still captures a delay slip.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 11'h000, (i == 1) ? 1'b1 : 1'b0, 1'b0);
    check_eq("freeze_state", state, 11'h555);
    run_chip(n);
    check_eq("freeze_dly_interval", n, 8);

    // All-zero load.
    cycle(1'b1, 1'b1, 11'h000, 1'b0, 1'b0);
`ifdef M_SEQ_LOCKUP_GUARD_EN
    check_eq("zero_guard_state", state, TB_SEED);
    check_eq("zero_guard_epoch", epoch, 1'b1);
    for (int c = 0; c < 5; c++) run_chip(n);
`else
    check_eq("zero_state", state, 11'h000);
    ep_n = 0;
    for (int c = 0; c < 100; c++) begin
      run_chip(n);
      if (n == 4 && state == 11'h000 && chip == 1'b0) ep_n++;
    end
    check_eq("zero_chips", ep_n, 100);
`endif

    // Asynchronous reset mid-chip.
    cycle(1'b1, 1'b1, 11'h123, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 11'h000, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check_eq("async_rst_state", state, TB_SEED);
    check_eq("async_rst_stb", chip_stb, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    run_chip(n);
    check_eq("post_rst_interval", n, 4);
    check_eq("post_rst_state", state, 11'h555);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
